// File: rtl/enigma_host_pkg.sv
// enigma_host_pkg: shared state encoding and table selectors for the enigma host sequencer
package enigma_host_pkg;
    typedef enum logic [2:0] {S_IDLE, S_LOAD_P, S_LOAD_A, S_LOAD_B, S_GAP, S_RUN, S_DRAIN} state_t;
    localparam logic [1:0] TBL_PLUG = 2'd0;
    localparam logic [1:0] TBL_A = 2'd1;
    localparam logic [1:0] TBL_B = 2'd2;
    localparam logic [1:0] TBL_NONE = 2'd3;
    localparam int ROTOR_ENTRIES = 64;
endpackage

// File: rtl/enigma_host_ctrl_if.sv
// enigma_host_ctrl_if: symbol input stream and result output stream of the host sequencer
interface enigma_host_ctrl_if;
    logic       s_valid;
    logic       s_ready;
    logic [5:0] s_data;
    logic       m_valid;
    logic       m_ready;
    logic [5:0] m_data;
    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/enigma_rsp_fifo.sv
// enigma_rsp_fifo: DEPTH x 6 synchronous result FIFO with occupancy count
module enigma_rsp_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [5:0]                   din,
    input  logic                         pop,
    output logic [5:0]                   dout,
    output logic [$clog2(DEPTH+1)-1:0]   used,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [5:0] mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic wr, rd, full;
    assign empty = used == '0;
    assign full = used == CW'(DEPTH);
    assign rd = pop && !empty;
    // a push into a full FIFO without a pop is a core protocol error and is dropped
    assign wr = push && (!full || rd);
    assign dout = mem[rp];
    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
            used <= '0;
        end else begin
            wp <= wp + AW'(wr);
            rp <= rp + AW'(rd);
            used <= used + CW'(wr) - CW'(rd);
        end
endmodule

// File: rtl/enigma_host_ctrl.sv
// enigma_host_ctrl: feeds rotor tables and text to the enigma core, buffers results with credit flow control.
// Define ENIGMA_PLUG_EN to load a 64-entry plugboard table before rotor A.
module enigma_host_ctrl
    import enigma_host_pkg::*;
#(
    parameter int LEN_W = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ENG_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_start,
    input  logic             cfg_mode,
    input  logic [LEN_W-1:0] cfg_len,
    enigma_host_ctrl_if.slave bus,
    output logic             load,
    output logic             encrypt,
    output logic [1:0]       table_idx,
    output logic             crypt_mode,
    output logic [5:0]       code_in,
    input  logic [5:0]       code_out,
    input  logic             code_valid,
    output logic             busy,
    output logic             done
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] CRED = (CW + 1)'(FIFO_DEPTH);
`ifdef ENIGMA_PLUG_EN
    localparam state_t FIRST = S_LOAD_P;
`else
    localparam state_t FIRST = S_LOAD_A;
`endif
    if (FIFO_DEPTH < ENG_LAT + 1) begin : g_depth_chk
        $error("FIFO_DEPTH too small to cover core latency");
    end
    state_t state, nxt_tbl;
    logic [LEN_W-1:0] len_q, txt_cnt;
    logic [5:0] ent_cnt;
    logic [CW-1:0] inflight, used;
    logic [1:0] tbl;
    logic empty, s_fire, issue, loading;
    assign loading = state == S_LOAD_P || state == S_LOAD_A || state == S_LOAD_B;
    assign s_fire = bus.s_valid && bus.s_ready;
    assign issue = s_fire && state == S_RUN;
    assign bus.m_valid = !empty;
    assign tbl = state == S_LOAD_P ? TBL_PLUG : state == S_LOAD_A ? TBL_A : TBL_B;
    assign nxt_tbl = state == S_LOAD_P ? S_LOAD_A : state == S_LOAD_A ? S_LOAD_B : S_GAP;
    // every symbol in flight or parked in the FIFO holds a credit, so the FIFO can never overflow
    always_comb
        bus.s_ready = state == S_RUN ? txt_cnt < len_q && {1'b0, used} + {1'b0, inflight} < CRED : loading;
    enigma_rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .rst_n(rst_n), .push(code_valid), .din(code_out),
        .pop(bus.m_valid && bus.m_ready), .dout(bus.m_data), .used(used), .empty(empty)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= S_IDLE;
            len_q <= '0;
            txt_cnt <= '0;
            ent_cnt <= '0;
            inflight <= '0;
            load <= 1'b0;
            encrypt <= 1'b0;
            table_idx <= TBL_NONE;
            crypt_mode <= 1'b0;
            code_in <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            load <= 1'b0;
            encrypt <= 1'b0;
            done <= 1'b0;
            inflight <= inflight + CW'(issue) - CW'(code_valid);
            if (s_fire) code_in <= bus.s_data;
            case (state)
                S_IDLE: if (cfg_start) begin
                    len_q <= cfg_len;
                    crypt_mode <= cfg_mode;
                    txt_cnt <= '0;
                    busy <= 1'b1;
                    state <= FIRST;
                end
                S_LOAD_P, S_LOAD_A, S_LOAD_B: if (s_fire) begin
                    load <= 1'b1;
                    table_idx <= tbl;
                    ent_cnt <= ent_cnt + 6'd1;
                    if (ent_cnt == 6'(ROTOR_ENTRIES - 1)) state <= nxt_tbl;
                end
                S_GAP: begin
                    table_idx <= TBL_NONE;
                    state <= len_q == '0 ? S_DRAIN : S_RUN;
                end
                S_RUN: if (s_fire) begin
                    encrypt <= 1'b1;
                    txt_cnt <= txt_cnt + LEN_W'(1);
                    if (txt_cnt + LEN_W'(1) == len_q) state <= S_DRAIN;
                end
                S_DRAIN: if (inflight == '0 && empty) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
endmodule

// File: tb/tb_enigma_host_ctrl.sv
// tb_enigma_host_ctrl: table of jobs with random tables/text, a stand-in core, and a golden cipher model
module tb_enigma_host_ctrl;
    import enigma_host_pkg::*;
    localparam int LEN_W = 8;
    localparam int FIFO_DEPTH = 4;
`ifdef ENIGMA_PLUG_EN
    localparam int NTAB = 3 * ROTOR_ENTRIES;
`else
    localparam int NTAB = 2 * ROTOR_ENTRIES;
`endif
    typedef struct {
        int len;
        bit mode;
        int vm;
        int mm;
        bit restart;
        int exp_load;
        int exp_enc;
    } job_t;

    logic clk = 1'b0, rst_n = 1'b0, cfg_start = 1'b0, cfg_mode = 1'b0;
    logic [LEN_W-1:0] cfg_len = '0;
    logic load, encrypt, crypt_mode, code_valid, busy, done;
    logic [1:0] table_idx;
    logic [5:0] code_in, code_out;
    int passed = 0, total = 0;

    enigma_host_ctrl_if bus();
    enigma_host_ctrl #(.LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH), .ENG_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_mode(cfg_mode), .cfg_len(cfg_len),
        .bus(bus), .load(load), .encrypt(encrypt), .table_idx(table_idx), .crypt_mode(crypt_mode),
        .code_in(code_in), .code_out(code_out), .code_valid(code_valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // stand-in core: stores tables as written, scrambles text by table lookup and step count
    logic [5:0] ra [64];
    logic [5:0] rb [64];
    int wa, wb, step;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            code_valid <= 1'b0;
            code_out <= '0;
            wa <= 0;
            wb <= 0;
            step <= 0;
        end else begin
            code_valid <= encrypt;
            if (encrypt) begin
                code_out <= ra[(int'(code_in) + step) % 64] ^ rb[(step * 7 + int'(crypt_mode)) % 64];
                step <= step + 1;
            end
            if (load && table_idx == TBL_A) begin
                ra[wa % 64] <= code_in;
                wa <= wa + 1;
            end
            if (load && table_idx == TBL_B) begin
                rb[wb % 64] <= code_in;
                wb <= wb + 1;
            end
        end

    logic [5:0] ga [64];
    logic [5:0] gb [64];
    logic [5:0] exp_q [256];
    logic [5:0] stream [$];

    int cyc = 0, jfire = 0, jpops = 0, jload = 0, jenc = 0, jmv = 0;
    int err_load = 0, err_enc = 0, err_idx = 0, err_data = 0, max_out = 0;
    int first_load = -1, last_load = -1, first_enc = -1, last_enc = -1, last_pop = -1;
    int done_cyc = -1, ndone = 0;
    logic pend_tab = 1'b0, pend_txt = 1'b0;

    // port monitor: every accepted beat must reappear on load/encrypt exactly one cycle later
    always @(negedge clk) begin : mon
        int o;
        logic f;
        cyc++;
        if (!rst_n) begin
            pend_tab = 1'b0;
            pend_txt = 1'b0;
        end else begin
            if (cfg_start && !busy) begin
                jfire = 0; jpops = 0; jload = 0; jenc = 0; jmv = 0;
                err_load = 0; err_enc = 0; err_idx = 0; err_data = 0; max_out = 0;
                first_load = -1; last_load = -1; first_enc = -1; last_enc = -1; last_pop = -1;
            end
            if (load !== pend_tab) err_load++;
            if (encrypt !== pend_txt) err_enc++;
            if (load) begin
                if (table_idx !== 2'((jload + 3 * ROTOR_ENTRIES - NTAB) / ROTOR_ENTRIES)) err_idx++;
                if (first_load < 0) first_load = cyc;
                last_load = cyc;
                jload++;
            end
            if (encrypt) begin
                if (table_idx !== TBL_NONE) err_idx++;
                if (first_enc < 0) first_enc = cyc;
                last_enc = cyc;
                jenc++;
            end
            f = bus.s_valid && bus.s_ready;
            pend_tab = f && jfire < NTAB;
            pend_txt = f && jfire >= NTAB;
            if (f) jfire++;
            o = (jfire > NTAB ? jfire - NTAB : 0) - jpops;
            if (o > max_out) max_out = o;
            if (bus.m_valid) jmv++;
            if (bus.m_valid && bus.m_ready) begin
                if (jpops >= 256 || bus.m_data !== exp_q[jpops]) err_data++;
                jpops++;
                last_pop = cyc;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act == exp_v) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
    endtask

    function automatic int outs();
        return int'({load, encrypt, table_idx, crypt_mode, code_in, bus.s_ready, bus.m_valid, busy, done});
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic build_job(input int len, input bit mode);
        logic [5:0] t;
        stream.delete();
        for (int k = 0; k < 64; k++) begin
            ga[k] = 6'($urandom);
            gb[k] = 6'($urandom);
        end
`ifdef ENIGMA_PLUG_EN
        for (int k = 0; k < 64; k++) stream.push_back(6'($urandom));
`endif
        for (int k = 0; k < 64; k++) stream.push_back(ga[k]);
        for (int k = 0; k < 64; k++) stream.push_back(gb[k]);
        for (int k = 0; k < len; k++) begin
            t = 6'($urandom);
            stream.push_back(t);
            exp_q[k] = ga[(int'(t) + k) % 64] ^ gb[(k * 7 + int'(mode)) % 64];
        end
    endtask

    task automatic start_job(input int len, input bit mode);
        cfg_len = LEN_W'(len);
        cfg_mode = mode;
        cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
    endtask

    task automatic drive(input int n, input int vm);
        int idx = 0, c = 0;
        logic f;
        while (idx < n && c < 10000) begin
            bus.s_valid = vm == 0 ? 1'b1 : vm == 1 ? (c % 2) == 0 : 1'($urandom % 2);
            bus.s_data = stream[idx];
            @(negedge clk);
            f = bus.s_valid && bus.s_ready;
            @(posedge clk);
            #1;
            if (f) idx++;
            c++;
        end
        bus.s_valid = 1'b0;
        chk("drive_complete", idx, n);
    endtask

    task automatic mready(input int mm, input int d0);
        int c = 0, st = 0;
        while (ndone == d0 && c < 10000) begin
            bus.m_ready = mm == 2 ? 1'($urandom % 2) : !(mm == 1 && jenc >= 10 && st < 20);
            if (!bus.m_ready && mm == 1) st++;
            @(posedge clk);
            #1;
            c++;
        end
        bus.m_ready = 1'b1;
    endtask

    task automatic poke_start(input bit mode);
        for (int c = 0; c < 5000 && jenc < 5; c++) @(posedge clk);
        #1;
        cfg_len = LEN_W'(3);
        cfg_mode = !mode;
        cfg_start = 1'b1;
        @(posedge clk);
        #1 cfg_start = 1'b0;
    endtask

    task automatic run_job(input job_t j, input int n);
        int d0;
        do_reset();
        build_job(j.len, j.mode);
        start_job(j.len, j.mode);
        d0 = ndone;
        fork
            drive(NTAB + j.len, j.vm);
            mready(j.mm, d0);
            if (j.restart) poke_start(j.mode);
        join
        repeat (3) @(negedge clk);
        chk($sformatf("j%0d_loads", n), jload, j.exp_load);
        chk($sformatf("j%0d_encrypts", n), jenc, j.exp_enc);
        chk($sformatf("j%0d_results", n), jpops, j.len);
        chk($sformatf("j%0d_data_errs", n), err_data, 0);
        chk($sformatf("j%0d_load_align_errs", n), err_load, 0);
        chk($sformatf("j%0d_enc_align_errs", n), err_enc, 0);
        chk($sformatf("j%0d_table_idx_errs", n), err_idx, 0);
        chk($sformatf("j%0d_credit_bound", n), int'(max_out <= FIFO_DEPTH), 1);
        chk($sformatf("j%0d_done_pulses", n), ndone - d0, 1);
        chk($sformatf("j%0d_busy_after_done", n), int'(busy), 0);
        if (j.len > 0) chk($sformatf("j%0d_done_after_pop", n), int'(done_cyc > last_pop), 1);
        else chk($sformatf("j%0d_no_m_valid", n), jmv, 0);
        if (j.mm == 1) chk($sformatf("j%0d_credit_full", n), max_out, FIFO_DEPTH);
        if (n == 0) begin
            chk("j0_load_span", last_load - first_load + 1, NTAB);
            chk("j0_gap_cycles", first_enc - last_load - 1, 1);
            chk("j0_enc_span", last_enc - first_enc + 1, j.len);
        end
    endtask

    task automatic reset_mid_load_b();
        do_reset();
        build_job(10, 1'b1);
        start_job(10, 1'b1);
        drive(NTAB - ROTOR_ENTRIES + 30, 0);
        chk("midb_pre_table_idx", int'(table_idx), int'(TBL_B));
        chk("midb_pre_busy", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midb_reset_outputs", outs(), 'h1800);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midb_idle_after_reset", outs(), 'h1800);
    endtask

    job_t jobs [7];

    initial begin
        jobs[0] = '{27, 1'b0, 0, 0, 1'b0, NTAB, 27};
        jobs[1] = '{27, 1'b0, 1, 0, 1'b0, NTAB, 27};
        jobs[2] = '{112, 1'b1, 0, 1, 1'b0, NTAB, 112};
        jobs[3] = '{0, 1'b0, 0, 0, 1'b0, NTAB, 0};
        jobs[4] = '{40, 1'b1, 0, 0, 1'b1, NTAB, 40};
        jobs[5] = '{60, 1'b0, 2, 2, 1'b0, NTAB, 60};
        jobs[6] = '{255, 1'b1, 2, 2, 1'b0, NTAB, 255};
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", outs(), 'h1800);
        for (int i = 0; i < 7; i++) run_job(jobs[i], i);
        reset_mid_load_b();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
